// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA timing generator. It holds the 640x480@60
// default geometry, the derived line and frame totals, and the coordinate
// width and type that the timing generator and its consumers use.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // 640x480@60 defaults. All values are in pixels or lines.
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

endpackage

// File: rtl/pix_tick_div.sv
// -----------------------------------------------------------------------------
// pix_tick_div
// Pixel-clock prescaler. It counts system clocks from 0 to CLK_DIV-1 and
// then wraps. p_tick is high for the single clock in which the counter sits
// at its last value.
// Ports:
//   clk     in   system clock
//   reset_n in   asynchronous active-low reset (counter -> 0)
//   p_tick  out  one-clk pixel enable, every CLK_DIV clks
// -----------------------------------------------------------------------------
module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          w_last;

    assign w_last = (r_div_cnt == DIV_LAST);
    assign p_tick = w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_div_cnt <= '0;
        else if (w_last) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running VGA pixel-timing source. It produces the pixel enable, the
// current pixel coordinate, registered active-low sync signals, video_on, and
// a pulse that marks the start of vertical blanking.
// Ports:
//   clk        in   system clock (only clock)
//   reset_n    in   asynchronous active-low reset
//   p_tick     out  pixel enable, one clk in every CLK_DIV
//   x, y       out  current column / line (10 bit)
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  inside the visible area
//   frame_tick out  one-clk pulse when the pixel at (0, V_DISPLAY) is ticked
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t V_BLANK0 = coord_t'(V_DISPLAY);

    // The window bounds use one extra bit so that a sync pulse ending exactly
    // at a total of 1024 does not wrap to zero.
    localparam logic [COORD_W:0] H_VIS    = (COORD_W+1)'(H_DISPLAY);
    localparam logic [COORD_W:0] V_VIS    = (COORD_W+1)'(V_DISPLAY);
    localparam logic [COORD_W:0] HS_START = (COORD_W+1)'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W:0] HS_END   = (COORD_W+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W:0] VS_START = (COORD_W+1)'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W:0] VS_END   = (COORD_W+1)'(V_DISPLAY + V_FRONT + V_SYNC);

    logic   w_p_tick;
    coord_t r_x, r_y;
    coord_t w_x_nxt, w_y_nxt;
    logic   r_hsync, r_vsync, r_video_on;
    logic   w_hsync_nxt, w_vsync_nxt, w_video_on_nxt;

    pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (w_p_tick)
    );

    // Next raster position. It holds between pixel ticks, so the registered
    // decodes below also hold between ticks.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_p_tick) begin
            if (r_x == H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == V_LAST) ? '0 : r_y + 1'b1;
            end else begin
                w_x_nxt = r_x + 1'b1;
            end
        end
    end

    // The sync and video decodes use the next position. They are registered
    // alongside x/y so that all of these outputs change on the same edge.
    always_comb begin
        w_hsync_nxt    = !(({1'b0, w_x_nxt} >= HS_START) && ({1'b0, w_x_nxt} < HS_END));
        w_vsync_nxt    = !(({1'b0, w_y_nxt} >= VS_START) && ({1'b0, w_y_nxt} < VS_END));
        w_video_on_nxt = ({1'b0, w_x_nxt} < H_VIS) && ({1'b0, w_y_nxt} < V_VIS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b1;
        end else begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_hsync    <= w_hsync_nxt;
            r_vsync    <= w_vsync_nxt;
            r_video_on <= w_video_on_nxt;
        end
    end

    assign p_tick     = w_p_tick;
    assign x          = r_x;
    assign y          = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    // This pulse is decoded only from registers, so it fires once per frame at
    // the first pixel tick of the first blanking line.
    assign frame_tick = w_p_tick && (r_x == '0) && (r_y == V_BLANK0);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A uses the default 640x480 geometry with CLK_DIV=4.
    logic       pt_a, hs_a, vs_a, von_a, ft_a;
    logic [9:0] x_a, y_a;
    // Instance B uses a small geometry (24x19 totals) with CLK_DIV=2. This
    // lets whole frames, wraps and vsync/frame_tick run within a short time.
    logic       pt_b, hs_b, vs_b, von_b, ft_b;
    logic [9:0] x_b, y_b;

    vga_timing_gen dut_a (
        .clk(clk), .reset_n(reset_n), .p_tick(pt_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .frame_tick(ft_a)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .p_tick(pt_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .frame_tick(ft_b)
    );

    obs_t got_a, got_b;
    assign got_a = {pt_a, x_a, y_a, hs_a, vs_a, von_a, ft_a};
    assign got_b = {pt_b, x_b, y_b, hs_b, vs_b, von_b, ft_b};

    obs_t qa[$];
    obs_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   c = 0;   // clk edges seen with reset_n high since the last reset

    // Reference model: pixel index = clks since release / CLK_DIV. The raster
    // position and all decodes follow from that index with plain arithmetic.
    function automatic obs_t model(int cyc, int d, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        int   ht;
        int   vt;
        int   k;
        int   px;
        int   py;
        obs_t o;
        ht    = hd + hf + hs + hb;
        vt    = vd + vf + vs + vb;
        k     = cyc / d;
        px    = k % ht;
        py    = (k / ht) % vt;
        o.pt  = ((cyc % d) == d - 1);
        o.x   = 10'(px);
        o.y   = 10'(py);
        o.hs  = !(px >= hd + hf && px < hd + hf + hs);
        o.vs  = !(py >= vd + vf && py < vd + vf + vs);
        o.von = (px < hd) && (py < vd);
        o.ft  = o.pt && (px == 0) && (py == vd);
        return o;
    endfunction

    task automatic push();
        qa.push_back(model(c, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        qb.push_back(model(c, 2, 16, 2, 3, 3, 12, 2, 2, 3));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) c++;
        #1;
        push();
    endtask

    task automatic release_step();
        @(posedge clk);
        if (reset_n) c++;
        #1;
        reset_n = 1'b1;
        push();
    endtask

    // Reset is asserted 1 time unit after an edge. The next sample (at the
    // falling edge) therefore shows whether the reset acted asynchronously.
    task automatic reset_pulse(input int hold);
        @(posedge clk);
        if (reset_n) c++;
        #1;
        reset_n = 1'b0;
        c = 0;
        push();
        repeat (hold - 1) step();
        release_step();
    endtask

    task automatic compare(input obs_t e, input obs_t g, input string name);
        checks++;
        if (e !== g) begin
            errors++;
            if (errors <= 10)
                $display("FAIL %s t=%0t got pt=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b want pt=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b",
                         name, $time, g.pt, g.x, g.y, g.hs, g.vs, g.von, g.ft,
                         e.pt, e.x, e.y, e.hs, e.vs, e.von, e.ft);
        end
    endtask

    // Monitor: the outputs run freely, so each falling edge is a presentation.
    always @(negedge clk) begin
        if (qa.size() > 0) compare(qa.pop_front(), got_a, "dut_a");
        if (qb.size() > 0) compare(qb.pop_front(), got_b, "dut_b");
    end

    int n1, n2, n3;

    initial begin
        n1 = 7000 + int'($urandom_range(0, 1500));
        n2 = 3500 + int'($urandom_range(0, 1500));
        n3 = 2000 + int'($urandom_range(0, 1000));
        reset_n = 1'b0;
        repeat (3) step();
        release_step();
        run_cycles(n1);
        reset_pulse(3);
        run_cycles(n2);
        reset_pulse(int'($urandom_range(1, 4)));
        run_cycles(n3);
        @(negedge clk);
        @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing source for the pong display: generates 640x480@60 Hz VGA sync, pixel-enable tick, and the current pixel coordinate consumed by the drawing/animation logic. It is the producer end of the x/y/sync interface that the draw block reads. It replaces ad-hoc decodes in consumers with a registered frame-boundary pulse.

## Interface

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz → 25 MHz); legal range 2..16.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  input  1  system clock, 100 MHz; the block's only clock.
- reset_n  input  1  asynchronous, active-low reset.
- p_tick  output  1  one-clk pixel enable, high once every CLK_DIV clks.
- x  output  10  current column, 0..H_TOTAL-1.
- y  output  10  current line, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- video_on  output  1  high when x<H_DISPLAY and y<V_DISPLAY.
- frame_tick  output  1  one-clk pulse marking the start of vertical blanking.

## Operation

- H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525. Both must be ≤1024, and the widths are fixed at 10 bits.
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), decoded from the register.
- On each clk edge where p_tick is high, the pixel position advances:
  - x increments.
  - At x == H_TOTAL-1, x wraps to 0 and y increments.
  - At x == H_TOTAL-1 and y == V_TOTAL-1, both wrap to 0.
  - At any other edge, x and y hold.
- hsync, vsync and video_on are registered. They update on the same edge as x/y and always equal these functions of the new (x,y):
  - hsync = 0 iff H_DISPLAY+H_FRONT ≤ x < H_DISPLAY+H_FRONT+H_SYNC, i.e. x in 656..751.
  - vsync = 0 iff V_DISPLAY+V_FRONT ≤ y < V_DISPLAY+V_FRONT+V_SYNC, i.e. y in 490..491.
  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
- frame_tick = p_tick && (x == 0) && (y == V_DISPLAY). It is high for exactly one clk per frame, so consumers update game state during blanking.

## Timing

- Reset (reset_n low, takes effect asynchronously):
  - div_cnt=0, x=0, y=0.
  - hsync=1, vsync=1, video_on=1, p_tick=0, frame_tick=0.
- After reset_n releases, the first p_tick is high during the CLK_DIV-th clk (div_cnt 0,1,..,CLK_DIV-1).
- Pixel (0,0) is presented for exactly CLK_DIV clks after release. Every later pixel is also presented for exactly CLK_DIV clks.
- Latency: x/y/hsync/vsync/video_on change together, one clk edge after the clk in which p_tick is high. There is no skew between them.
- Line period: H_TOTAL·CLK_DIV = 3200 clks. Frame period: 3200·525 = 1,680,000 clks.
- Reset asserted mid-frame: all state returns to reset values immediately, with no completion of the current line. The timing after release is identical to power-up.
- There is no handshake and no backpressure; outputs are free-running.

## Structure

- Package `vga_timing_pkg` holds:
  - the 640x480@60 default constants (H_*/V_* values);
  - derived H_TOTAL and V_TOTAL;
  - the 10-bit coordinate width.
- Optional sub-module `pix_tick_div` contains the CLK_DIV prescaler (counter plus p_tick decode). The x/y counters and sync decodes stay in the top.

## Test plan

- Reset hold then release → all outputs at their reset values while reset_n is low; first p_tick on the 4th clk after release; x=1 on the following edge.
- Run one full line → x sequences 0..799 then wraps to 0, y 0→1; line length 3200 clks; hsync low for exactly 96 ticks (x 656..751).
- Run one full frame → vsync low only for y=490..491 (1600 pixel ticks); video_on high for exactly 640·480 ticks; frame_tick one pulse, coincident with p_tick at x=0, y=480.
- End-of-frame wrap → at x=799, y=524 with p_tick high, the next edge gives x=0, y=0, video_on=1, vsync=1.
- Assert reset_n at x=300, y=200 for 3 clks → outputs go to reset values asynchronously; after release, behaviour matches the power-up check.
- Override CLK_DIV=2 → p_tick every 2 clks; line period 1600 clks; sync positions unchanged in pixel units.
